// File: rtl/video_timing_pkg.sv
// Raster constants, sync polarity codes and per-pixel flag record shared by video timing cores.
// Defaults describe a 15 kHz 512x240 mode; the totals are derived with the helper functions.
package video_timing_pkg;

  localparam int DEF_H_ACTIVE = 512;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 64;
  localparam int DEF_H_BP     = 80;
  localparam int DEF_V_ACTIVE = 240;
  localparam int DEF_V_FP     = 4;
  localparam int DEF_V_SYNC   = 3;
  localparam int DEF_V_BP     = 15;

  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;

  // Raster attributes of one counter position, sync bits held active-high internally.
  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic hb;
    logic vb;
    logic line_first;
    logic frame_first;
  } raster_flags_t;

  localparam raster_flags_t FLAGS_BLANK = '{
    act: 1'b0, hs: 1'b0, vs: 1'b0, hb: 1'b1, vb: 1'b1,
    line_first: 1'b0, frame_first: 1'b0
  };

  function automatic int h_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int v_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/pix_ce_gen.sv
// Pixel clock enable from a free-running 2-bit divider: clk_sys/4 or clk_sys/2.
// Combinational from the divider register, so a rate change applies on the next clk_sys.
module pix_ce_gen (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic ce_divider,
  output logic ce_pix
);

  logic [1:0] div_q;
  logic [1:0] div_d;

  assign div_d = div_q + 2'd1;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= 2'd0;
    end else begin
      div_q <= div_d;
    end
  end

  // Both modes fire only on odd counts, so switching can never produce back-to-back enables.
  assign ce_pix = ce_divider ? div_q[0] : (div_q == 2'd3);

endmodule

// File: rtl/video_timing_gen.sv
// Raster generator for mist_video: counters, fetch request, sync/blank and pixel output stage.
// Counter state at enable k reaches R/G/B/syncs at enable k+1; run=0 stops only at a frame boundary.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int   H_ACTIVE    = DEF_H_ACTIVE,
  parameter int   H_FP        = DEF_H_FP,
  parameter int   H_SYNC      = DEF_H_SYNC,
  parameter int   H_BP        = DEF_H_BP,
  parameter int   V_ACTIVE    = DEF_V_ACTIVE,
  parameter int   V_FP        = DEF_V_FP,
  parameter int   V_SYNC      = DEF_V_SYNC,
  parameter int   V_BP        = DEF_V_BP,
  parameter logic SYNC_POL    = SYNC_ACTIVE_LOW,
  parameter int   HCNT_WIDTH  = 10,
  parameter int   VCNT_WIDTH  = 9,
  parameter int   COLOR_DEPTH = 6
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   ce_divider,
  input  logic                   run,
  output logic                   ce_pix,
  output logic                   fetch_req,
  output logic [HCNT_WIDTH-1:0]  fetch_x,
  output logic [VCNT_WIDTH-1:0]  fetch_y,
  input  logic [COLOR_DEPTH-1:0] pix_r,
  input  logic [COLOR_DEPTH-1:0] pix_g,
  input  logic [COLOR_DEPTH-1:0] pix_b,
  output logic [COLOR_DEPTH-1:0] R,
  output logic [COLOR_DEPTH-1:0] G,
  output logic [COLOR_DEPTH-1:0] B,
  output logic                   HSync,
  output logic                   VSync,
  output logic                   HBlank,
  output logic                   VBlank,
  output logic                   line_start,
  output logic                   frame_start
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [HCNT_WIDTH-1:0] H_LAST = HCNT_WIDTH'(H_TOTAL - 1);
  localparam logic [HCNT_WIDTH-1:0] H_ACT  = HCNT_WIDTH'(H_ACTIVE);
  localparam logic [HCNT_WIDTH-1:0] H_SS   = HCNT_WIDTH'(H_ACTIVE + H_FP);
  localparam logic [HCNT_WIDTH-1:0] H_SE   = HCNT_WIDTH'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VCNT_WIDTH-1:0] V_LAST = VCNT_WIDTH'(V_TOTAL - 1);
  localparam logic [VCNT_WIDTH-1:0] V_ACT  = VCNT_WIDTH'(V_ACTIVE);
  localparam logic [VCNT_WIDTH-1:0] V_SS   = VCNT_WIDTH'(V_ACTIVE + V_FP);
  localparam logic [VCNT_WIDTH-1:0] V_SE   = VCNT_WIDTH'(V_ACTIVE + V_FP + V_SYNC);

  logic [HCNT_WIDTH-1:0]  hcnt_q, hcnt_d;
  logic [VCNT_WIDTH-1:0]  vcnt_q, vcnt_d;
  logic                   running_q, running_d;
  raster_flags_t          cur_flags, dly_q, dly_d;
  logic [COLOR_DEPTH-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic                   hsync_q, hsync_d, vsync_q, vsync_d;
  logic                   hblank_q, hblank_d, vblank_q, vblank_d;
  logic                   advance, active, h_wrap, v_wrap;

  pix_ce_gen u_pix_ce (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .ce_divider (ce_divider),
    .ce_pix     (ce_pix)
  );

  // A stopped raster restarts from (0,0) on the very enable that sees run high.
  assign advance = running_q | run;
  assign active  = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
  assign h_wrap  = (hcnt_q == H_LAST);
  assign v_wrap  = (vcnt_q == V_LAST);

  always_comb begin
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    running_d = running_q;
    if (ce_pix && advance) begin
      running_d = 1'b1;
      if (h_wrap) begin
        hcnt_d = '0;
        if (v_wrap) begin
          vcnt_d    = '0;
          running_d = run;
        end else begin
          vcnt_d = vcnt_q + VCNT_WIDTH'(1);
        end
      end else begin
        hcnt_d = hcnt_q + HCNT_WIDTH'(1);
      end
    end
  end

  assign fetch_req = ce_pix & active & advance;
  assign fetch_x   = hcnt_q;
  assign fetch_y   = vcnt_q;

  always_comb begin
    cur_flags = FLAGS_BLANK;
    if (advance) begin
      cur_flags.act         = active;
      cur_flags.hs          = (hcnt_q >= H_SS) && (hcnt_q < H_SE);
      cur_flags.vs          = (vcnt_q >= V_SS) && (vcnt_q < V_SE);
      cur_flags.hb          = !(hcnt_q < H_ACT);
      cur_flags.vb          = !(vcnt_q < V_ACT);
      cur_flags.line_first  = (hcnt_q == '0);
      cur_flags.frame_first = (hcnt_q == '0) && (vcnt_q == '0);
    end
  end

  assign dly_d = ce_pix ? cur_flags : dly_q;

  always_comb begin
    r_d      = r_q;
    g_d      = g_q;
    b_d      = b_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    hblank_d = hblank_q;
    vblank_d = vblank_q;
    if (ce_pix) begin
      r_d      = dly_q.act ? pix_r : '0;
      g_d      = dly_q.act ? pix_g : '0;
      b_d      = dly_q.act ? pix_b : '0;
      hsync_d  = dly_q.hs ? SYNC_POL : ~SYNC_POL;
      vsync_d  = dly_q.vs ? SYNC_POL : ~SYNC_POL;
      hblank_d = dly_q.hb;
      vblank_d = dly_q.vb;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      running_q <= 1'b1;
      dly_q     <= FLAGS_BLANK;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      hsync_q   <= ~SYNC_POL;
      vsync_q   <= ~SYNC_POL;
      hblank_q  <= 1'b1;
      vblank_q  <= 1'b1;
    end else begin
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      running_q <= running_d;
      dly_q     <= dly_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      hblank_q  <= hblank_d;
      vblank_q  <= vblank_d;
    end
  end

  assign R      = r_q;
  assign G      = g_q;
  assign B      = b_q;
  assign HSync  = hsync_q;
  assign VSync  = vsync_q;
  assign HBlank = hblank_q;
  assign VBlank = vblank_q;

  // Markers coincide with the enable that loads the first pixel of a line/frame into the outputs.
  assign line_start  = ce_pix & dly_q.line_first;
  assign frame_start = ce_pix & dly_q.frame_first;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a reduced 16x10 raster (8x6 active).
module tb_video_timing_gen;

  localparam int HA = 8, HFP = 2, HS = 3, HBP = 3, HT = 16;
  localparam int VA = 6, VFP = 1, VS = 2, VBP = 1, VT = 10;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic       ce_divider = 1'b0;
  logic       run = 1'b1;
  logic [5:0] pix_r = 6'h2A, pix_g = 6'h15, pix_b = 6'h3F;
  logic       ce_pix, fetch_req;
  logic [9:0] fetch_x;
  logic [8:0] fetch_y;
  logic [5:0] R, G, B;
  logic       HSync, VSync, HBlank, VBlank, line_start, frame_start;

  always #5 clk_sys = ~clk_sys;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(1'b0), .HCNT_WIDTH(10), .VCNT_WIDTH(9), .COLOR_DEPTH(6)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce_divider(ce_divider), .run(run),
    .ce_pix(ce_pix), .fetch_req(fetch_req), .fetch_x(fetch_x), .fetch_y(fetch_y),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .R(R), .G(G), .B(B), .HSync(HSync), .VSync(VSync),
    .HBlank(HBlank), .VBlank(VBlank),
    .line_start(line_start), .frame_start(frame_start)
  );

  typedef struct packed {
    logic [5:0] r, g, b;
    logic hs, vs, hb, vb, ls, fs;
  } exp_t;

  localparam exp_t BLANK = '{r: 6'd0, g: 6'd0, b: 6'd0, hs: 1'b1, vs: 1'b1,
                             hb: 1'b1, vb: 1'b1, ls: 1'b0, fs: 1'b0};

  int   checks = 0, errors = 0;
  exp_t q[$];
  exp_t cur, pend;
  bit   load_pend, mrun;
  int   exp_div, mx, my, cyc, ce_idx, fetch_cnt, resume_ce, hs_fall_prev, first_ce_cyc, fs_cnt;
  logic hs_prev;
  logic [9:0] src_x;
  logic [8:0] src_y;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d pos %0d,%0d)", tag, got, exp, cyc, mx, my);
    end
  endtask

  function automatic exp_t pix_exp(input int x, input int y);
    exp_t e;
    logic act;
    act  = (x < HA) && (y < VA);
    e.r  = act ? 6'(x) : 6'd0;
    e.g  = act ? 6'(y) : 6'd0;
    e.b  = act ? 6'h3F : 6'd0;
    e.hs = !((x >= HA + HFP) && (x < HA + HFP + HS));
    e.vs = !((y >= VA + VFP) && (y < VA + VFP + VS));
    e.hb = (x >= HA);
    e.vb = (y >= VA);
    e.ls = (x == 0);
    e.fs = (x == 0) && (y == 0);
    return e;
  endfunction

  task automatic model_reset();
    exp_div = 0; mx = 0; my = 0; mrun = 1'b1;
    q.delete();
    q.push_back(BLANK);
    cur = BLANK; load_pend = 1'b0;
    fetch_cnt = 0; hs_prev = 1'b1; hs_fall_prev = -1;
    cyc = 0; ce_idx = 0; resume_ce = -1; first_ce_cyc = -1;
  endtask

  // Pixel source stub: answers each fetch one clk_sys later and holds until the next one.
  initial forever begin
    @(negedge clk_sys);
    if (fetch_req === 1'b1) begin
      src_x = fetch_x;
      src_y = fetch_y;
      @(posedge clk_sys);
      #1;
      pix_r = src_x[5:0];
      pix_g = src_y[5:0];
    end
  end

  task automatic step();
    logic ce_e, adv, act;
    @(negedge clk_sys);
    cyc++;
    if (load_pend) begin
      cur = pend;
      load_pend = 1'b0;
    end
    check("R", R, cur.r);
    check("G", G, cur.g);
    check("B", B, cur.b);
    check("HSync", HSync, cur.hs);
    check("VSync", VSync, cur.vs);
    check("HBlank", HBlank, cur.hb);
    check("VBlank", VBlank, cur.vb);
    ce_e = ce_divider ? (exp_div % 2 == 1) : (exp_div == 3);
    check("ce_pix", ce_pix, ce_e);
    if (ce_e && first_ce_cyc < 0) first_ce_cyc = cyc;
    if (fetch_req === 1'b1) fetch_cnt++;
    if (ce_e) begin
      ce_idx++;
      pend = q.pop_front();
      load_pend = 1'b1;
      check("line_start", line_start, pend.ls);
      check("frame_start", frame_start, pend.fs);
      if (frame_start === 1'b1 && resume_ce >= 0) begin
        check("resume_fs_delay", ce_idx - resume_ce, 1);
        resume_ce = -1;
      end
      adv = mrun || run;
      act = (mx < HA) && (my < VA);
      check("fetch_req", fetch_req, adv && act);
      if (adv && act) begin
        check("fetch_x", fetch_x, mx);
        check("fetch_y", fetch_y, my);
      end
      if (adv) begin
        if (!mrun) begin
          resume_ce = ce_idx;
          hs_fall_prev = -1;
        end
        q.push_back(pix_exp(mx, my));
        mrun = (mx == HT - 1 && my == VT - 1) ? run : 1'b1;
        mx++;
        if (mx == HT) begin
          mx = 0;
          my++;
          if (my == VT) begin
            my = 0;
            check("fetches_per_frame", fetch_cnt, HA * VA);
            fetch_cnt = 0;
          end
        end
      end else begin
        q.push_back(BLANK);
      end
    end else begin
      check("fetch_req_idle", fetch_req, 0);
      check("line_start_idle", line_start, 0);
      check("frame_start_idle", frame_start, 0);
    end
    if (hs_prev && !HSync) begin
      if (hs_fall_prev >= 0) check("hsync_period", cyc - hs_fall_prev, ce_divider ? 2 * HT : 4 * HT);
      hs_fall_prev = cyc;
    end
    hs_prev = HSync;
    exp_div = (exp_div + 1) % 4;
  endtask

  task automatic set_div(input logic v);
    @(posedge clk_sys);
    #1;
    ce_divider = v;
    hs_fall_prev = -1;
  endtask

  task automatic set_run(input logic v);
    @(posedge clk_sys);
    #1;
    run = v;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk_sys);
    #1 reset_n = 1'b1;
    repeat (200) step();

    // Asynchronous reset in the middle of an active line.
    @(posedge clk_sys);
    #2 reset_n = 1'b0;
    #1;
    check("rst_R", R, 0);
    check("rst_G", G, 0);
    check("rst_B", B, 0);
    check("rst_HSync", HSync, 1);
    check("rst_VSync", VSync, 1);
    check("rst_HBlank", HBlank, 1);
    check("rst_VBlank", VBlank, 1);
    check("rst_fetch_req", fetch_req, 0);
    check("rst_line_start", line_start, 0);
    check("rst_frame_start", frame_start, 0);
    model_reset();
    repeat (2) @(posedge clk_sys);
    #1 reset_n = 1'b1;
    repeat (40) step();
    check("first_ce_cycle", first_ce_cyc, 4);
    repeat (2 * HT * VT * 4 - 20) step();

    set_div(1'b1);
    repeat (2 * HT * VT * 2 + 30) step();

    // Stop request in the middle of line 3.
    for (int i = 0; i < 4000 && !(my == 3 && mx == 5); i++) step();
    check("reach_line3", my, 3);
    set_run(1'b0);
    fs_cnt = 0;
    for (int i = 0; i < 4000 && mrun; i++) begin
      step();
      if (frame_start === 1'b1) fs_cnt++;
    end
    check("stopped", mrun, 0);
    repeat (60) begin
      step();
      if (frame_start === 1'b1) fs_cnt++;
    end
    check("stop_no_frame_start", fs_cnt, 0);
    check("stop_hcnt", fetch_x, 0);
    check("stop_vcnt", fetch_y, 0);

    set_run(1'b1);
    repeat (HT * VT * 2 + 50) step();
    check("resume_frame_start_seen", resume_ce, -1);

    set_div(1'b0);
    repeat (400) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
